// File: rtl/seq_hit_window_monitor.sv
// seq_hit_window_monitor: counts sequence-detector hits over fixed windows of
// WINDOW cycles and posts each window's count as a valid/ready result, with a
// sticky threshold interrupt and a sticky unread-result overrun flag.
// Optional macro HIT_FIRST_OFFSET_EN adds res_first, the in-window cycle
// index of the first hit of the reported window (all-ones when no hit).
module seq_hit_window_monitor #(
    parameter int WINDOW = 1000,
    parameter int CNT_W  = 8,
    parameter int THRESH = 4,
    parameter int WIN_W  = $clog2(WINDOW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             success,
    input  logic             res_ready,
    input  logic             status_clr,
    output logic             res_valid,
    output logic [CNT_W-1:0] res_count,
    output logic             res_sat,
    output logic             irq,
    output logic             overrun,
    output logic             busy
`ifdef HIT_FIRST_OFFSET_EN
    ,
    output logic [WIN_W-1:0] res_first
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HIT_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

    state_t             state_q;
    state_t             state_d;
    logic               counting;
    logic [WIN_W-1:0]   win_cnt;
    logic [CNT_W-1:0]   hit_cnt;
    logic               sat_q;
    logic               win_end;
    logic               hit_at_max;
    logic [CNT_W-1:0]   total;
    logic               sat_total;
    logic               transfer;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, busy, and whether this cycle counts toward the window
    always_comb begin
        state_d  = state_q;
        busy     = 1'b0;
        counting = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (en) begin
                    counting = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating hit total including the current cycle; en low in RUN
    // discards the window, even in its last cycle
    always_comb begin
        hit_at_max = (hit_cnt == HIT_MAX);
        total      = hit_cnt;
        if (success && !hit_at_max) begin
            total = hit_cnt + CNT_W'(1);
        end
        sat_total = sat_q | (success & hit_at_max);
        win_end   = counting && (win_cnt == WIN_LAST);
        transfer  = res_valid && res_ready;
    end

    // Window cycle counter, hit counter and saturation flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt <= '0;
            hit_cnt <= '0;
            sat_q   <= 1'b0;
        end else if (!counting || win_end) begin
            win_cnt <= '0;
            hit_cnt <= '0;
            sat_q   <= 1'b0;
        end else begin
            win_cnt <= win_cnt + WIN_W'(1);
            hit_cnt <= total;
            sat_q   <= sat_total;
        end
    end

    // Result register and valid/ready handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_count <= '0;
            res_sat   <= 1'b0;
        end else if (win_end) begin
            res_valid <= 1'b1;
            res_count <= total;
            res_sat   <= sat_total;
        end else if (transfer) begin
            res_valid <= 1'b0;
        end
    end

    // Sticky status flags; a set in the same cycle as status_clr wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (win_end && (total >= THRESH_V)) begin
                irq <= 1'b1;
            end else if (status_clr) begin
                irq <= 1'b0;
            end
            if (win_end && res_valid && !res_ready) begin
                overrun <= 1'b1;
            end else if (status_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef HIT_FIRST_OFFSET_EN
    logic [WIN_W-1:0] first_q;
    logic             seen_q;

    // Offset of the first hit in the running window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q <= '0;
            seen_q  <= 1'b0;
        end else if (!counting || win_end) begin
            first_q <= '0;
            seen_q  <= 1'b0;
        end else if (success && !seen_q) begin
            first_q <= win_cnt;
            seen_q  <= 1'b1;
        end
    end

    // First-hit offset loaded alongside res_count; a hit in the last
    // cycle of an otherwise empty window reports WINDOW-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_first <= '0;
        end else if (win_end) begin
            if (seen_q) begin
                res_first <= first_q;
            end else if (success) begin
                res_first <= win_cnt;
            end else begin
                res_first <= '1;
            end
        end
    end
`endif

endmodule
